// File: rtl/xadac_obi_sram.sv
// xadac_obi_sram
// ---------------------------------------------------------------------------
// OBI slave in front of a single-port synchronous SRAM. Each accepted request
// produces exactly one R-channel response, and responses come back in
// acceptance order.
//
// Handshakes:
//   A channel: a request is accepted on a rising edge where req && gnt.
//   R channel: a response is consumed on a rising edge where rvalid && rready.
//              While rvalid=1 and rready=0, rvalid/rdata/rid/err hold stable.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req, gnt          A-channel request / grant
//   addr, we, be,     byte address, write enable, byte enables,
//   wdata, aid        write data, request ID
//   rvalid, rready    R-channel valid / ready
//   rdata, rid, err   read data (0 for writes and errors), response ID,
//                     out-of-range flag
//
// Datapath: acceptance edge -> stage register (+ SRAM read port) -> either
// straight onto the R channel (bypass, when the FIFO is empty) or into the
// response FIFO. Credit for the FIFO is reserved at grant time, so a push
// can never overflow.
// ---------------------------------------------------------------------------
module xadac_obi_sram #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 128,
    parameter int IdWidth   = 2,
    parameter int NumWords  = 1024,
    parameter int RespDepth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    output logic                   gnt,
    input  logic [AddrWidth-1:0]   addr,
    input  logic                   we,
    input  logic [DataWidth/8-1:0] be,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [IdWidth-1:0]     aid,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [DataWidth-1:0]   rdata,
    output logic [IdWidth-1:0]     rid,
    output logic                   err
);

    localparam int NumBytes = DataWidth / 8;
    localparam int ByteOffs = $clog2(NumBytes);
    localparam int IdxWidth = AddrWidth - ByteOffs;
    localparam int MemAw    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int PtrW     = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int CntW     = $clog2(RespDepth + 1);
    localparam int EntryW   = IdWidth + 1 + DataWidth;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IdxWidth-1:0] word_idx;
    logic                in_range;
    logic [MemAw-1:0]    mem_addr;
    logic                unused_addr_bits;

    assign word_idx         = addr[AddrWidth-1:ByteOffs];
    assign in_range         = {1'b0, word_idx} < (IdxWidth+1)'(NumWords);
    assign mem_addr         = word_idx[MemAw-1:0];
    // Sub-word address bits carry no meaning for a full-width word access.
    assign unused_addr_bits = ^addr[ByteOffs-1:0];

    // ------------------------------------------------------------------
    // Grant: outstanding = responses already in the FIFO plus the one in
    // the stage. A same-cycle pop earns no credit, which keeps gnt free of
    // any dependency on rready.
    // ------------------------------------------------------------------
    logic [CntW-1:0] fifo_count;
    logic            stage_valid;
    logic [CntW:0]   outstanding;
    logic            accept;
    logic            acc_rd;
    logic            acc_wr;

    assign outstanding = {1'b0, fifo_count} + {{CntW{1'b0}}, stage_valid};
    assign gnt         = req & ~rst & (outstanding < (CntW+1)'(RespDepth));
    assign accept      = req & gnt;
    assign acc_rd      = accept & ~we & in_range;
    assign acc_wr      = accept &  we & in_range;

    // ------------------------------------------------------------------
    // SRAM: byte-masked write at the acceptance edge, registered read.
    // Contents are never reset. acc_wr already excludes reset via gnt.
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] mem [NumWords];
    logic [DataWidth-1:0] sram_q;

    always_ff @(posedge clk) begin
        if (acc_wr) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (be[b]) begin
                    mem[mem_addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (acc_rd) begin
            sram_q <= mem[mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Stage register: one cycle after acceptance it describes the response.
    // ------------------------------------------------------------------
    logic [IdWidth-1:0]   stage_id;
    logic                 stage_err;
    logic                 stage_we;
    logic [DataWidth-1:0] stage_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_id    <= '0;
            stage_err   <= 1'b0;
            stage_we    <= 1'b0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_id  <= aid;
                stage_err <= ~in_range;
                stage_we  <= we;
            end
        end
    end

    // Writes and out-of-range requests answer with zero data.
    assign stage_data = (stage_valid && !stage_err && !stage_we) ? sram_q : '0;

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic [EntryW-1:0] fifo_mem [RespDepth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [EntryW-1:0] stage_entry;

    assign fifo_empty  = (fifo_count == '0);
    assign stage_entry = {stage_id, stage_err, stage_data};
    assign pop         = ~fifo_empty & rready;
    // The stage skips the FIFO only when it is on the bus and taken at once.
    assign push        = stage_valid & ~(fifo_empty & rready);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= stage_entry;
        end
    end

    // ------------------------------------------------------------------
    // R channel: FIFO head has priority since it holds older responses.
    // ------------------------------------------------------------------
    always_comb begin
        rvalid = 1'b0;
        rid    = '0;
        err    = 1'b0;
        rdata  = '0;
        if (!fifo_empty) begin
            rvalid              = 1'b1;
            {rid, err, rdata}   = fifo_mem[rd_ptr];
        end else if (stage_valid) begin
            rvalid = 1'b1;
            rid    = stage_id;
            err    = stage_err;
            rdata  = stage_data;
        end
    end

endmodule

// File: doc/xadac_obi_sram.md
XADAC_OBI_SRAM -- requirements
Module: xadac_obi_sram

Interface
Parameters (name, default, meaning):
REQ-001 AddrWidth, 32, OBI address width.
REQ-002 DataWidth, 128, OBI data width; one vector per word.
REQ-003 IdWidth, 2, OBI transaction ID width.
REQ-004 NumWords, 1024, SRAM depth in DataWidth words.
REQ-005 RespDepth, 4, response FIFO depth and maximum responses outstanding.

Ports (name, direction, width, meaning):
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 req  in  1  OBI A-channel request.
REQ-009 gnt  out  1  OBI A-channel grant.
REQ-010 addr  in  AddrWidth  byte address.
REQ-011 we  in  1  write enable.
REQ-012 be  in  DataWidth/8  byte enables.
REQ-013 wdata  in  DataWidth  write data.
REQ-014 aid  in  IdWidth  request ID.
REQ-015 rvalid  out  1  R-channel valid.
REQ-016 rready  in  1  R-channel ready.
REQ-017 rdata  out  DataWidth  read data.
REQ-018 rid  out  IdWidth  response ID; equals the aid of the request being answered.
REQ-019 err  out  1  the request being answered was out of range.

Function
REQ-020 A transfer is accepted on any cycle where req and gnt are both high.
REQ-021 gnt = req AND (fifo_count + stage_valid < RespDepth).
  - gnt takes no credit from a same-cycle R-channel pop.
  - gnt is combinational on req and registered state only.
REQ-022 Word index = addr[AddrWidth-1 : log2(DataWidth/8)]; low address bits are ignored.
REQ-023 Out of range: word index >= NumWords.
  - No SRAM access is performed.
  - The response carries err=1 and rdata=0.
REQ-024 Accepted write: for each byte b where be[b]=1, write wdata byte b to the indexed word at the acceptance edge.
  - Bytes where be[b]=0 are unchanged.
  - The response carries rdata=0 and err=0.
REQ-025 Accepted read: the SRAM is read synchronously; data is available in the next cycle.
  - The response carries the word contents and err=0.
REQ-026 Stage register: on acceptance in cycle N, the stage holds {valid, id, err, we} and the SRAM output in cycle N+1.
REQ-027 Bypass: if the FIFO is empty in cycle N+1, the stage drives rvalid/rdata/rid/err directly in N+1.
  - If rready=1 in that cycle, the response completes and nothing is pushed.
  - Otherwise the stage is pushed into the FIFO at the end of N+1.
REQ-028 If the FIFO is not empty, the stage is always pushed and the R channel is driven from the FIFO head.
REQ-029 Responses complete strictly in acceptance order; IDs are never reordered.
REQ-030 While rvalid=1 and rready=0, rvalid/rdata/rid/err hold stable until the handshake.
REQ-031 A push and a pop in the same cycle are both performed; fifo_count is unchanged.
  - Pointers wrap modulo RespDepth.
REQ-032 Read-after-write: a read accepted in cycle N+1 to a word written in cycle N returns the new data.
REQ-033 Same-cycle write acceptance and read of the same word cannot occur (one request per cycle).
REQ-034 The SRAM contents are not reset and are undefined until written.

Reset
REQ-035 While rst=1 at a rising edge, the following are cleared:
  - gnt = 0;
  - rvalid = 0, rdata = 0, rid = 0, err = 0;
  - fifo_count, read/write pointers and stage_valid = 0.
REQ-036 Reset mid-operation discards all outstanding responses; no response is issued for requests accepted before reset.
REQ-037 SRAM writes are suppressed while rst=1.

Verification
REQ-038 Write then read, be all-ones:
  - write 0x0010 data 0x0123..EF, aid=1;
  - read 0x0010, aid=2, rready=1;
  - -> responses rid=1 (rdata=0), then rid=2 (rdata=0x0123..EF), each one cycle after acceptance.
REQ-039 Partial write:
  - write all-ones to 0x20;
  - write zeros to 0x20 with be=0x000F;
  - read 0x20 -> rdata=0xFFFF..FFFF_0000_0000.
REQ-040 Backpressure:
  - rready=0, 6 back-to-back reads with aid 0,1,2,3,0,1;
  - -> exactly 4 grants, gnt low thereafter;
  - raise rready -> rid sequence 0,1,2,3;
  - the remaining two are then granted and return rid 0,1.
REQ-041 Out of range: read addr = NumWords*16 -> err=1, rdata=0, rid echoed; the SRAM is unchanged.
REQ-042 Reset mid-flight: 3 reads accepted, rready=0, then assert rst for 1 cycle -> rvalid=0 from the next cycle and no stale responses afterwards.
REQ-043 Simultaneous push/pop:
  - continuous reads with rready toggling every cycle;
  - -> fifo_count never exceeds RespDepth, no lost or duplicated rid, order preserved.
